// File: rtl/reg_port_sequencer.sv
// Single-port register file sequencer: arbitrates writeback vs operand reads.
// Optional RF_ZERO_REG_EN hardwires register 0 to zero.
module reg_port_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  output logic        rd_ready,
  input  logic [4:0]  rs_a,
  input  logic [4:0]  rs_b,
  output logic        op_valid,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        wb_req,
  input  logic [4:0]  wb_sel,
  input  logic [31:0] wb_data,
  output logic        wb_ack,
  output logic [4:0]  rf_sel,
  output logic        rf_read_write,
  output logic        rf_enable,
  output logic [31:0] rf_data_in,
  input  logic [31:0] rf_data_out
);

`ifdef RF_ZERO_REG_EN
  localparam bit ZeroEn = 1'b1;
`else
  localparam bit ZeroEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_A,
    RD_B,
    CAP
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  wb_sel_q, wb_sel_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  rs_a_q, rs_a_d;
  logic [4:0]  rs_b_q, rs_b_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        op_valid_q, op_valid_d;
  logic        zero_a, zero_b, zero_wb;

  assign zero_a  = ZeroEn && (rs_a_q == 5'd0);
  assign zero_b  = ZeroEn && (rs_b_q == 5'd0);
  assign zero_wb = ZeroEn && (wb_sel_q == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wb_sel_q   <= '0;
      wb_data_q  <= '0;
      rs_a_q     <= '0;
      rs_b_q     <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_sel_q   <= wb_sel_d;
      wb_data_q  <= wb_data_d;
      rs_a_q     <= rs_a_d;
      rs_b_q     <= rs_b_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wb_sel_d   = wb_sel_q;
    wb_data_d  = wb_data_q;
    rs_a_d     = rs_a_q;
    rs_b_d     = rs_b_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb_req) begin
          wb_sel_d  = wb_sel;
          wb_data_d = wb_data;
          state_d   = WRITE;
        end else if (rd_req) begin
          rs_a_d  = rs_a;
          rs_b_d  = rs_b;
          state_d = RD_A;
        end
      end
      WRITE: state_d = IDLE;
      RD_A:  state_d = RD_B;
      // file output now holds the rs_a read issued in RD_A
      RD_B: begin
        op_a_d  = zero_a ? 32'h0 : rf_data_out;
        state_d = CAP;
      end
      CAP: begin
        op_b_d     = zero_b ? 32'h0 : rf_data_out;
        op_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_sel        = 5'd0;
    rf_read_write = 1'b0;
    rf_enable     = 1'b0;
    rf_data_in    = 32'h0;
    wb_ack        = 1'b0;
    unique case (state_q)
      WRITE: begin
        rf_sel        = wb_sel_q;
        rf_read_write = 1'b1;
        rf_enable     = !zero_wb;
        rf_data_in    = wb_data_q;
        wb_ack        = 1'b1;
      end
      RD_A: begin
        rf_sel    = rs_a_q;
        rf_enable = 1'b1;
      end
      RD_B: begin
        rf_sel    = rs_b_q;
        rf_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_ready = (state_q == IDLE) && !wb_req;
  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Directed bench for reg_port_sequencer with a behavioural register file.
// Table of write/read vectors plus hand sequences for arbitration and reset.
module tb_reg_port_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic        rd_ready;
  logic [4:0]  rs_a, rs_b;
  logic        op_valid;
  logic [31:0] op_a, op_b;
  logic        wb_req;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic [4:0]  rf_sel;
  logic        rf_read_write;
  logic        rf_enable;
  logic [31:0] rf_data_in;
  logic [31:0] rf_data_out;

  int errors = 0;
  int checks = 0;

  reg_port_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_ready(rd_ready),
    .rs_a(rs_a), .rs_b(rs_b),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .wb_req(wb_req), .wb_sel(wb_sel), .wb_data(wb_data),
    .wb_ack(wb_ack),
    .rf_sel(rf_sel), .rf_read_write(rf_read_write),
    .rf_enable(rf_enable), .rf_data_in(rf_data_in),
    .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // register file: registered read, one-cycle latency
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (rf_enable) begin
      if (rf_read_write) mem[rf_sel] <= rf_data_in;
      else rf_data_out <= mem[rf_sel];
    end
  end

  typedef struct {
    bit          wr;
    logic [4:0]  sel_a;
    logic [4:0]  sel_b;
    logic [31:0] data;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " op_valid"}, {31'b0, op_valid}, 32'h0);
    check({tag, " op_a"}, op_a, 32'h0);
    check({tag, " op_b"}, op_b, 32'h0);
    check({tag, " wb_ack"}, {31'b0, wb_ack}, 32'h0);
    check({tag, " rf_enable"}, {31'b0, rf_enable}, 32'h0);
    check({tag, " rf_rw"}, {31'b0, rf_read_write}, 32'h0);
    check({tag, " rf_sel"}, {27'b0, rf_sel}, 32'h0);
    check({tag, " rf_data_in"}, rf_data_in, 32'h0);
  endtask

  task automatic do_write(input logic [4:0] s, input logic [31:0] d,
                          input logic exp_en);
    @(negedge clk);
    wb_req = 1'b1; wb_sel = s; wb_data = d;
    #1 check("wr rd_ready", {31'b0, rd_ready}, 32'h0);
    @(negedge clk);
    check("wr ack", {31'b0, wb_ack}, 32'h1);
    check("wr en", {31'b0, rf_enable}, {31'b0, exp_en});
    check("wr rw", {31'b0, rf_read_write}, 32'h1);
    check("wr sel", {27'b0, rf_sel}, {27'b0, s});
    check("wr data", rf_data_in, d);
    wb_req = 1'b0;
    @(negedge clk);
    check("wr ack drop", {31'b0, wb_ack}, 32'h0);
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] ea, input logic [31:0] eb);
    @(negedge clk);
    rd_req = 1'b1; rs_a = a; rs_b = b;
    #1 check("rd ready", {31'b0, rd_ready}, 32'h1);
    @(negedge clk);
    rd_req = 1'b0;
    check("rda sel", {27'b0, rf_sel}, {27'b0, a});
    check("rda en", {31'b0, rf_enable}, 32'h1);
    check("rda rw", {31'b0, rf_read_write}, 32'h0);
    @(negedge clk);
    check("rdb sel", {27'b0, rf_sel}, {27'b0, b});
    check("rdb valid", {31'b0, op_valid}, 32'h0);
    @(negedge clk);
    check("cap en", {31'b0, rf_enable}, 32'h0);
    check("cap valid", {31'b0, op_valid}, 32'h0);
    @(negedge clk);
    check("rd valid", {31'b0, op_valid}, 32'h1);
    check("rd op_a", op_a, ea);
    check("rd op_b", op_b, eb);
    check("rd ready c4", {31'b0, rd_ready}, 32'h1);
    @(negedge clk);
    check("rd valid drop", {31'b0, op_valid}, 32'h0);
  endtask

  initial begin
    logic        zen;
    logic [31:0] zexp;
`ifdef RF_ZERO_REG_EN
    zen  = 1'b0;
    zexp = 32'h0;
`else
    zen  = 1'b1;
    zexp = 32'hFF;
`endif
    vecs[0] = '{1'b1, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd5,  5'd5, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd3,  5'd0, 32'h11, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 5'd7,  5'd0, 32'h22, 32'h0, 32'h0};
    vecs[4] = '{1'b0, 5'd3,  5'd7, 32'h0, 32'h11, 32'h22};
    vecs[5] = '{1'b0, 5'd7,  5'd3, 32'h0, 32'h22, 32'h11};
    vecs[6] = '{1'b1, 5'd31, 5'd0, 32'hA5A5A5A5, 32'h0, 32'h0};
    vecs[7] = '{1'b0, 5'd31, 5'd5, 32'h0, 32'hA5A5A5A5, 32'hDEADBEEF};

    rst_n = 1'b0; rd_req = 1'b0; wb_req = 1'b0;
    rs_a = '0; rs_b = '0; wb_sel = '0; wb_data = '0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    check("reset rd_ready", {31'b0, rd_ready}, 32'h1);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) do_write(vecs[i].sel_a, vecs[i].data, 1'b1);
      else do_read(vecs[i].sel_a, vecs[i].sel_b,
                   vecs[i].exp_a, vecs[i].exp_b);
    end

    // simultaneous requests: write must win, read sees new value
    @(negedge clk);
    wb_req = 1'b1; wb_sel = 5'd3; wb_data = 32'h99;
    rd_req = 1'b1; rs_a = 5'd3; rs_b = 5'd7;
    #1 check("sim rd_ready", {31'b0, rd_ready}, 32'h0);
    @(negedge clk);
    check("sim ack", {31'b0, wb_ack}, 32'h1);
    check("sim rw", {31'b0, rf_read_write}, 32'h1);
    wb_req = 1'b0;
    #1 check("sim ready in write", {31'b0, rd_ready}, 32'h0);
    @(negedge clk);
    check("sim ready idle", {31'b0, rd_ready}, 32'h1);
    @(negedge clk);
    rd_req = 1'b0;
    check("sim rda sel", {27'b0, rf_sel}, 32'd3);
    repeat (3) @(negedge clk);
    check("sim valid", {31'b0, op_valid}, 32'h1);
    check("sim op_a", op_a, 32'h99);
    check("sim op_b", op_b, 32'h22);

    // reset during RD_B abandons the read
    @(negedge clk);
    rd_req = 1'b1; rs_a = 5'd5; rs_b = 5'd5;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    check("pre-rst rdb sel", {27'b0, rf_sel}, 32'd5);
    rst_n = 1'b0;
    #1 check_reset_outs("mid reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst no valid", {31'b0, op_valid}, 32'h0);
      check("rst no en", {31'b0, rf_enable}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst valid", {31'b0, op_valid}, 32'h0);

    // register 0 behaviour depends on build option
    do_write(5'd0, 32'hFF, zen);
    do_read(5'd0, 5'd0, zexp, zexp);
    do_read(5'd0, 5'd5, zexp, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
